log_arbiter: RTL

- Round-robin arbiter and sequencer that shares one fixed-point log2 core (1.M.N format, valid/ready on both sides) among REQ requesters.
- Accepts one request at a time, screens out operands the core cannot handle, and forwards each valid operand to the core.
- Collects the core result and returns it on a shared response bus to the requester that issued it.
- Sits between the requester front-ends and the single log2 core instance.

---
 rtl/log_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/log_arbiter.sv
// log_arbiter: round-robin arbiter that shares one 1.M.N log2 core among REQ requesters.
// One transaction is in flight at a time. Zero and negative operands are answered
// locally with an error response, so the core never sees them.
module log_arbiter #(
    parameter int unsigned REQ = 4,
    parameter int unsigned M   = 4,
    parameter int unsigned N   = 10,
    parameter int unsigned W   = M + N + 1,
    parameter int unsigned IW  = $clog2(REQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ-1:0]    req_valid,
    output logic [REQ-1:0]    req_ready,
    input  logic [REQ*W-1:0]  req_data,
    output logic [REQ-1:0]    rsp_valid,
    input  logic [REQ-1:0]    rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic [W-1:0]      core_number,
    output logic              core_ivalid,
    input  logic              core_iready,
    input  logic [W-1:0]      core_lognumber,
    input  logic              core_ovalid,
    output logic              core_oready,
    output logic              busy,
    output logic [IW-1:0]     grant_id
);

    if (REQ < 2 || REQ > 8) begin : g_bad_req
        $error("log_arbiter: REQ must be in 2..8");
    end
    if (W != M + N + 1) begin : g_bad_w
        $error("log_arbiter: W must equal M+N+1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRes, StRespond} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  grant_q;
    logic [W-1:0]   number_q;
    logic           ivalid_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_err_q;

    logic           win_found;
    logic [IW-1:0]  win_id;
    logic [W-1:0]   win_data;
    logic           win_bad;
    logic           accept;

    // Round-robin scan starting at ptr: first valid requester wins.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < REQ; k++) begin
            idx = (32'(ptr_q) + k) % REQ;
            if (!win_found && req_valid[IW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    // Operand screening: zero would hang the core's scaling loop, negatives have no log.
    assign win_data = req_data[32'(win_id) * W +: W];
    assign win_bad  = (win_data == '0) || win_data[W-1];
    assign accept   = (state_q == StIdle) && win_found && !reset;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = win_bad ? StRespond : StIssue;
            StIssue:   if (core_iready) state_d = StWaitRes;
            StWaitRes: if (core_ovalid) state_d = StRespond;
            StRespond: if (rsp_ready[grant_q]) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath registers: grant bookkeeping, core operand and response value.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            grant_q    <= '0;
            number_q   <= '0;
            ivalid_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q <= win_id;
                        ptr_q   <= (win_id == IW'(REQ - 1)) ? '0 : win_id + IW'(1);
                        if (win_bad) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end else begin
                            number_q <= win_data;
                            ivalid_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (core_iready) ivalid_q <= 1'b0;
                end
                StWaitRes: begin
                    if (core_ovalid) begin
                        rsp_data_q <= core_lognumber;
                        rsp_err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: handshakes decoded from state, data from registers.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept) req_ready[win_id] = 1'b1;
        if (state_q == StRespond) rsp_valid[grant_q] = 1'b1;
        core_oready = (state_q == StWaitRes) && core_ovalid;
        busy        = (state_q != StIdle);
        grant_id    = grant_q;
        core_number = number_q;
        core_ivalid = ivalid_q;
        rsp_data    = rsp_data_q;
        rsp_err     = rsp_err_q;
    end

endmodule
